vpu_timing_issuer: RTL and testbench

// - Command-issue side of the VPU timing-counter interface.
// - Accepts one VPU request at a time from the address decoder (valid/ready).
// - Holds the request until every timing constraint it depends on has expired.
// - Presents the request as a command to the execution unit (valid/ready).
// - On each issued command, loads the external saturating down-counters
//   (GAP, WTR, EX) through their reset_cmd/reset_value ports, and reads back

---
 rtl/vpu_timing_issuer.sv | 85 ++++++++
 tb/tb_vpu_timing_issuer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_timing_issuer.sv
// vpu_timing_issuer: holds one VPU request until its GAP/WTR/EX timing counters
// have expired, issues it as a command, and reloads the counters on issue.
module vpu_timing_issuer #(
  parameter int CNTR_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 16,
  parameter int T_CMD       = 1,
  parameter int T_WTR       = 3,
  parameter int T_EX        = 6,
  parameter int STALL_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_op_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic [1:0]              cmd_op_o,
  output logic [ADDR_WIDTH-1:0]   cmd_addr_o,
  output logic [2:0]              tcnt_reset_cmd_o,
  output logic [3*CNTR_WIDTH-1:0] tcnt_reset_value_o,
  input  logic [2:0]              tcnt_is_zero_i,
  output logic                    busy_o,
  output logic [STALL_WIDTH-1:0]  stall_cnt_o
);
  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;
  localparam logic [1:0] OP_EX  = 2'd3;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;
  logic                   elig, hs;

  if (T_CMD >= 2**CNTR_WIDTH || T_WTR >= 2**CNTR_WIDTH || T_EX >= 2**CNTR_WIDTH) begin : g_bad_timing
    $error("vpu_timing_issuer: a T_* value does not fit in CNTR_WIDTH bits");
  end

  // Only RD waits on write-to-read turnaround; GAP and EX gate every command.
  assign elig               = tcnt_is_zero_i[0] && tcnt_is_zero_i[2] && (op_q != OP_RD || tcnt_is_zero_i[1]);
  assign cmd_valid_o        = rst_n && state_q == HOLD && elig;
  assign hs                 = cmd_valid_o && cmd_ready_i;
  assign tcnt_reset_cmd_o   = hs ? {op_q == OP_EX, op_q == OP_WR, 1'b1} : 3'b000;
  assign tcnt_reset_value_o = {CNTR_WIDTH'(T_EX), CNTR_WIDTH'(T_WTR), CNTR_WIDTH'(T_CMD)};
  assign req_ready_o        = rst_n && state_q == IDLE;
  assign busy_o             = state_q == HOLD;
  assign cmd_op_o           = op_q;
  assign cmd_addr_o         = addr_q;
  assign stall_cnt_o        = stall_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    stall_d = (state_q == HOLD && !elig && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    if (state_q == IDLE) begin
      if (req_valid_i && req_op_i != OP_NOP) begin
        state_d = HOLD;
        op_d    = req_op_i;
        addr_d  = req_addr_i;
      end
    end else if (hs) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_vpu_timing_issuer.sv
// tb_vpu_timing_issuer: scoreboard bench with behavioural saturating down-counters
// standing in for the external GAP/WTR/EX timing counters.
module tb_vpu_timing_issuer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid_i = 0;
  logic        req_ready_o;
  logic [1:0]  req_op_i = 0;
  logic [15:0] req_addr_i = 0;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1;
  logic [1:0]  cmd_op_o;
  logic [15:0] cmd_addr_o;
  logic [2:0]  tcnt_reset_cmd_o;
  logic [11:0] tcnt_reset_value_o;
  logic [2:0]  tcnt_is_zero_i;
  logic        busy_o;
  logic [15:0] stall_cnt_o;

  vpu_timing_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_addr_i(req_addr_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_addr_o(cmd_addr_o),
    .tcnt_reset_cmd_o(tcnt_reset_cmd_o), .tcnt_reset_value_o(tcnt_reset_value_o),
    .tcnt_is_zero_i(tcnt_is_zero_i), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] op; logic [15:0] addr;} req_t;
  localparam logic [3:0] TV [3] = '{4'd1, 4'd3, 4'd6};

  int   tests = 0, fails = 0, cyc = 0;
  int   hs_cnt = 0, hs_cyc = 0, rise_cyc = 0;
  logic prev_v = 0;
  req_t sb[$];
  logic [3:0] cnt [3];

  always @(posedge clk) cyc <= cyc + 1;

  // GAP=[0], WTR=[1], EX=[2]: load on pulse, otherwise count down to zero
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (!rst_n) cnt[i] <= 0;
      else if (tcnt_reset_cmd_o[i]) cnt[i] <= TV[i];
      else if (cnt[i] != 0) cnt[i] <= cnt[i] - 1;

  always_comb for (int i = 0; i < 3; i++) tcnt_is_zero_i[i] = (cnt[i] == 0);

  always @(negedge clk) begin
    req_t e;
    logic [2:0] ep;
    if (cmd_valid_o && !prev_v) rise_cyc = cyc;
    prev_v = cmd_valid_o;
    if (cmd_valid_o && cmd_ready_i) begin
      hs_cyc = cyc;
      hs_cnt++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_cmd: got op=%0d addr=%h, required no command", cmd_op_o, cmd_addr_o);
      end else begin
        e  = sb.pop_front();
        ep = {e.op == 2'd3, e.op == 2'd2, 1'b1};
        if ({cmd_op_o, cmd_addr_o} !== {e.op, e.addr}) begin
          fails++;
          $display("FAIL cmd_payload: got op=%0d addr=%h, required op=%0d addr=%h", cmd_op_o, cmd_addr_o, e.op, e.addr);
        end
        tests++;
        if (tcnt_reset_cmd_o !== ep) begin
          fails++;
          $display("FAIL load_pulse: got %b, required %b", tcnt_reset_cmd_o, ep);
        end
      end
    end else begin
      tests++;
      if (tcnt_reset_cmd_o !== 3'b000) begin
        fails++;
        $display("FAIL stray_pulse: got %b, required 000 at cycle %0d", tcnt_reset_cmd_o, cyc);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [15:0] a);
    bit done = 0;
    req_valid_i = 1; req_op_i = op; req_addr_i = a;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (req_ready_o) begin
        if (op != 0) sb.push_back({op, a});
        done = 1;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL accept_timeout: got req_ready_o=0, required 1 within 60 cycles");
    end
    @(posedge clk); #1;
    req_valid_i = 0;
  endtask

  task automatic wait_hs();
    int n = hs_cnt;
    for (int i = 0; i < 60 && hs_cnt == n; i++) @(negedge clk);
    tests++;
    if (hs_cnt == n) begin
      fails++;
      $display("FAIL hs_timeout: got no handshake, required one within 60 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({req_ready_o, cmd_valid_o, busy_o, tcnt_reset_cmd_o} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b busy=%b pulse=%b, required all 0", req_ready_o, cmd_valid_o, busy_o, tcnt_reset_cmd_o);
    end
    tests++;
    if ({stall_cnt_o, cmd_op_o, cmd_addr_o} !== 34'b0) begin
      fails++;
      $display("FAIL reset_state: got stall=%0d op=%0d addr=%h, required 0", stall_cnt_o, cmd_op_o, cmd_addr_o);
    end
    tests++;
    if (tcnt_reset_value_o !== 12'h631) begin
      fails++;
      $display("FAIL reset_value: got %h, required 631", tcnt_reset_value_o);
    end
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    tests++;
    if (req_ready_o !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b, required 1", req_ready_o);
    end
    idle(2);
  endtask

  task automatic test_rd_rd();
    int t;
    send(2'd1, 16'h1001);
    send(2'd1, 16'h1002);
    t = hs_cyc;
    wait_hs();
    tests++;
    if (rise_cyc - t !== 2) begin
      fails++;
      $display("FAIL rd_rd_spacing: got %0d, required 2", rise_cyc - t);
    end
    idle(10);
  endtask

  task automatic test_wr_rd();
    int t;
    logic [15:0] s0;
    send(2'd2, 16'h2001);
    send(2'd1, 16'h2002);
    t  = hs_cyc;
    s0 = stall_cnt_o;
    wait_hs();
    tests++;
    if (rise_cyc - t !== 4) begin
      fails++;
      $display("FAIL wr_rd_spacing: got %0d, required 4", rise_cyc - t);
    end
    tests++;
    if (stall_cnt_o - s0 !== 16'd2) begin
      fails++;
      $display("FAIL wr_rd_stall: got +%0d, required +2", stall_cnt_o - s0);
    end
    idle(10);
  endtask

  task automatic test_ex_wr();
    int t;
    send(2'd3, 16'h3001);
    send(2'd2, 16'h3002);
    t = hs_cyc;
    wait_hs();
    tests++;
    if (rise_cyc - t !== 7) begin
      fails++;
      $display("FAIL ex_wr_spacing: got %0d, required 7", rise_cyc - t);
    end
    idle(10);
  endtask

  task automatic test_back_pressure();
    cmd_ready_i = 0;
    send(2'd2, 16'h4abc);
    for (int i = 0; i < 20 && !cmd_valid_o; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({cmd_valid_o, req_ready_o, cmd_op_o, cmd_addr_o} !== {1'b1, 1'b0, 2'd2, 16'h4abc}) begin
        fails++;
        $display("FAIL back_pressure: got valid=%b ready=%b op=%0d addr=%h, required 1 0 2 4abc", cmd_valid_o, req_ready_o, cmd_op_o, cmd_addr_o);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    cmd_ready_i = 1;
    wait_hs();
    idle(10);
  endtask

  task automatic test_nop_rd();
    send(2'd0, 16'h5555);
    tests++;
    if ({busy_o, req_ready_o, cmd_valid_o} !== 3'b010) begin
      fails++;
      $display("FAIL nop_discard: got busy=%b ready=%b valid=%b, required 0 1 0", busy_o, req_ready_o, cmd_valid_o);
    end
    send(2'd1, 16'h5001);
    wait_hs();
    idle(10);
  endtask

  task automatic test_reset_mid_hold();
    cmd_ready_i = 0;
    send(2'd1, 16'h6001);
    idle(2);
    tests++;
    if ({busy_o, cmd_valid_o} !== 2'b11 || stall_cnt_o == 16'd0) begin
      fails++;
      $display("FAIL pre_reset_hold: got busy=%b valid=%b stall=%0d, required 1 1 nonzero", busy_o, cmd_valid_o, stall_cnt_o);
    end
    rst_n = 0;
    cmd_ready_i = 1;
    @(negedge clk);
    tests++;
    if ({cmd_valid_o, req_ready_o} !== 2'b00) begin
      fails++;
      $display("FAIL reset_in_hold: got valid=%b ready=%b, required 0 0", cmd_valid_o, req_ready_o);
    end
    @(posedge clk); #1;
    rst_n = 1;
    sb.delete();
    tests++;
    if ({busy_o, stall_cnt_o} !== 17'b0) begin
      fails++;
      $display("FAIL reset_cleared: got busy=%b stall=%0d, required 0 0", busy_o, stall_cnt_o);
    end
    @(negedge clk);
    tests++;
    if ({req_ready_o, cmd_valid_o} !== 2'b10) begin
      fails++;
      $display("FAIL ready_after_deassert: got ready=%b valid=%b, required 1 0", req_ready_o, cmd_valid_o);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_rd_rd();
    test_wr_rd();
    test_ex_wr();
    test_back_pressure();
    test_nop_rd();
    test_reset_mid_hold();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
